// File: rtl/sw_pkg.sv
// Shared encodings for the switch-array controller: system modes,
// DAC sequencer states, pulse generator phases and the output FSM states.
package sw_pkg;

  // system_state encodings (0/5/6/7 all mean HOLD)
  localparam logic [2:0] SYS_HOLD   = 3'd0;
  localparam logic [2:0] SYS_SET    = 3'd1;
  localparam logic [2:0] SYS_TRAIN  = 3'd2;
  localparam logic [2:0] SYS_CLEAR0 = 3'd3;
  localparam logic [2:0] SYS_CLEAR1 = 3'd4;

  // dac_top_state encodings (11..15 unused, treated as "open all")
  localparam logic [3:0] DAC_IDLE     = 4'd0;
  localparam logic [3:0] DAC_V1_2     = 4'd1;
  localparam logic [3:0] DAC_CNT_1_2  = 4'd2;
  localparam logic [3:0] DAC_V2_2     = 4'd3;
  localparam logic [3:0] DAC_CNT_2_2  = 4'd4;
  localparam logic [3:0] DAC_V_READ   = 4'd5;
  localparam logic [3:0] DAC_COMPLETE = 4'd6;
  localparam logic [3:0] DAC_V1_1     = 4'd7;
  localparam logic [3:0] DAC_V2_1     = 4'd8;
  localparam logic [3:0] DAC_CNT_1_1  = 4'd9;
  localparam logic [3:0] DAC_CNT_2_1  = 4'd10;

  // pulse generator phases
  localparam logic [1:0] PULSE_IDLE = 2'd0;
  localparam logic [1:0] PULSE_ACT1 = 2'd1;
  localparam logic [1:0] PULSE_ACT2 = 2'd2;
  localparam logic [1:0] PULSE_END  = 2'd3;

  // break-before-make output FSM
  typedef enum logic {
    FSM_IDLE   = 1'b0,
    FSM_SETTLE = 1'b1
  } sw_fsm_e;

  // Both CLEAR encodings behave identically
  function automatic logic is_clear(input logic [2:0] sys);
    return (sys == SYS_CLEAR0) || (sys == SYS_CLEAR1);
  endfunction

endpackage

// File: rtl/sw_target_dec.sv
// Combinational decode of the next switch target vector from the system
// mode, DAC sequencer state and pulse phases. tgt_cur is the registered
// target, returned unchanged wherever the decode says "hold".
module sw_target_dec
  import sw_pkg::*;
#(
  parameter int N_CH = 16
) (
  input  logic              key_state,
  input  logic [2:0]        system_state,
  input  logic [3:0]        dac_top_state,
  input  logic [1:0]        pulse1_state,
  input  logic [1:0]        pulse2_state,
  input  logic [N_CH-1:0]   mask1,
  input  logic [N_CH-1:0]   mask2,
  input  logic [N_CH-1:0]   tgt_cur,
  output logic [N_CH-1:0]   tgt_next
);

  // Priority: key off, then system mode, then TRAIN sub-decode
  always_comb begin
    tgt_next = tgt_cur;
    if (!key_state) begin
      tgt_next = '0;
    end else if (system_state == SYS_SET) begin
      tgt_next = '1;
    end else if (is_clear(system_state)) begin
      tgt_next = '0;
    end else if (system_state == SYS_TRAIN) begin
      case (dac_top_state)
        DAC_V1_1: begin
          case (pulse1_state)
            PULSE_ACT1, PULSE_ACT2: tgt_next = mask1;
            PULSE_END:              tgt_next = '0;
            default:                tgt_next = tgt_cur;
          endcase
        end
        DAC_V1_2: begin
          case (pulse2_state)
            PULSE_ACT1, PULSE_ACT2: tgt_next = mask2;
            PULSE_END:              tgt_next = '0;
            default:                tgt_next = tgt_cur;
          endcase
        end
        DAC_CNT_1_2, DAC_V2_2, DAC_CNT_2_2,
        DAC_V2_1, DAC_CNT_1_1, DAC_CNT_2_1: tgt_next = tgt_cur;
        // IDLE, V_READ, COMPLETE and unused codes open every switch
        default: tgt_next = '0;
      endcase
    end
  end

endmodule

// File: rtl/sw_array_ctrl.sv
// Switch-array controller: registers a target switch vector from the
// sequencer state and drives sw_out. With SW_DEADTIME_EN defined, new
// closures are held back by a break-before-make dead time while openings
// take effect immediately. Without it, sw_out simply follows the target.
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        system_state,
  input  logic              key_state,
  input  logic [3:0]        dac_top_state,
  input  logic [1:0]        pulse1_state,
  input  logic [1:0]        pulse2_state,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N_CH-1:0]   cfg_mask1,
  input  logic [N_CH-1:0]   cfg_mask2,
  output logic [N_CH-1:0]   sw_out,
  output logic              busy
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("sw_array_ctrl: N_CH must be >= 1");
  end
  if (DEAD_CYC < 1) begin : g_bad_dead_cyc
    $error("sw_array_ctrl: DEAD_CYC must be >= 1");
  end

  logic [N_CH-1:0] mask1_q, mask1_d;
  logic [N_CH-1:0] mask2_q, mask2_d;
  logic [N_CH-1:0] tgt_q, tgt_d;
  logic [N_CH-1:0] sw_q, sw_d;

  // Masks may only change outside TRAIN and while no closure is pending
  assign cfg_ready = (system_state != SYS_TRAIN) && !busy;
  assign sw_out    = sw_q;

  // Mask load on a completed handshake; unaccepted requests are dropped
  always_comb begin
    mask1_d = mask1_q;
    mask2_d = mask2_q;
    if (cfg_valid && cfg_ready) begin
      mask1_d = cfg_mask1;
      mask2_d = cfg_mask2;
    end
  end

  sw_target_dec #(
    .N_CH(N_CH)
  ) u_target_dec (
    .key_state    (key_state),
    .system_state (system_state),
    .dac_top_state(dac_top_state),
    .pulse1_state (pulse1_state),
    .pulse2_state (pulse2_state),
    .mask1        (mask1_q),
    .mask2        (mask2_q),
    .tgt_cur      (tgt_q),
    .tgt_next     (tgt_d)
  );

  // Mask, target and switch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask1_q <= '1;
      mask2_q <= '1;
      tgt_q   <= '0;
      sw_q    <= '0;
    end else begin
      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
      tgt_q   <= tgt_d;
      sw_q    <= sw_d;
    end
  end

`ifdef SW_DEADTIME_EN

  localparam int CNT_W = $clog2(DEAD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  sw_fsm_e         state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  assign busy = busy_q;

  // Break-before-make: open immediately, close only after the dead time
  // with the target unchanged; a target change mid-wait restarts the wait
  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (!key_state) begin
      sw_d    = '0;
      state_d = FSM_IDLE;
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (tgt_q != sw_q) begin
            if ((tgt_q & ~sw_q) == '0) begin
              sw_d = tgt_q;
            end else begin
              sw_d    = sw_q & tgt_q;
              pend_d  = tgt_q;
              cnt_d   = CNT_RELOAD;
              state_d = FSM_SETTLE;
            end
          end
        end
        FSM_SETTLE: begin
          if (tgt_q != pend_q) begin
            sw_d   = sw_q & tgt_q;
            pend_d = tgt_q;
            cnt_d  = CNT_RELOAD;
          end else if (cnt_q == '0) begin
            sw_d    = pend_q;
            state_d = FSM_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = FSM_IDLE;
      endcase
    end
    busy_d = (state_d == FSM_SETTLE);
  end

  // FSM state, pending target, dead-time counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FSM_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`else

  assign busy = 1'b0;

  // No dead time: the switches follow the registered target directly
  always_comb begin
    sw_d = tgt_q;
  end

`endif

endmodule

// File: doc/sw_array_ctrl.md
SW_ARRAY_CTRL -- requirements
Module: sw_array_ctrl

Interface
REQ-001 Parameter N_CH, default 16, number of switch channels (>=1).
REQ-002 Parameter DEAD_CYC, default 4, break-before-make dead time in clk cycles (>=1).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 system_state  in  3  1=SET, 2=TRAIN, 3/4=CLEAR, 0/5/6/7=HOLD.
REQ-006 key_state  in  1  global enable; 0 forces switches open.
REQ-007 dac_top_state  in  4  DAC sequencer state (encoding in REQ-014).
REQ-008 pulse1_state, pulse2_state  in  2 each  pulse generator phase: 0=idle, 1/2=active, 3=end.
REQ-009 cfg_valid  in  1 / cfg_ready  out  1  mask load handshake.
REQ-010 cfg_mask1, cfg_mask2  in  N_CH each  channel participation masks for pulse1 / pulse2.
REQ-011 sw_out  out  N_CH  switch drive, 1=closed.
REQ-012 busy  out  1  dead-time wait in progress.

Function
REQ-013 The block SHALL register target vector tgt_q each cycle from the inputs, with one-cycle latency.
- key_state=0 -> 0.
- SET -> all ones.
- CLEAR -> 0.
- HOLD -> tgt_q.
REQ-014 In TRAIN, tgt_q SHALL follow dac_top_state:
- IDLE(0) -> 0.
- V1_1(7): pulse1 1/2 -> mask1_q; pulse1 3 -> 0; pulse1 0 -> hold.
- V1_2(1): pulse2 1/2 -> mask2_q; pulse2 3 -> 0; pulse2 0 -> hold.
- CNT_1_2(2), V2_2(3), CNT_2_2(4), V2_1(8), CNT_1_1(9), CNT_2_1(10) -> hold.
- V_READ(5), COMPLETE(6), 11..15 -> 0.
REQ-015 The output FSM SHALL have two states, IDLE and SETTLE, and a down-counter of width $clog2(DEAD_CYC+1).
REQ-016 IDLE, T=tgt_q: if T==sw_out, no change; if T has no new closures (T & ~sw_out == 0), sw_out<=T next cycle; else sw_out<=sw_out&T, latch T into pend, cnt<=DEAD_CYC-1, go SETTLE.
REQ-017 SETTLE: if tgt_q!=pend, sw_out<=sw_out&tgt_q, pend<=tgt_q, cnt reloads to DEAD_CYC-1; else if cnt==0, sw_out<=pend and go IDLE; else cnt decrements.
REQ-018 Closures SHALL therefore appear exactly DEAD_CYC+1 cycles after the opening step, with tgt_q stable throughout; openings SHALL never be delayed.
REQ-019 busy SHALL be 1 exactly while the FSM is in SETTLE.
REQ-020 key_state=0 SHALL override the FSM directly: sw_out<=0 and FSM<=IDLE in the next cycle, regardless of state.
REQ-021 cfg_ready SHALL be 1 iff system_state!=TRAIN and busy=0.
REQ-022 On cfg_valid&&cfg_ready, mask1_q/mask2_q SHALL load and be used from the next cycle; cfg_valid without cfg_ready SHALL be ignored and not queued.

Reset
REQ-023 On reset the block SHALL set: sw_out=0, tgt_q=0, pend=0, cnt=0, FSM=IDLE, busy=0, mask1_q=mask2_q=all ones.
REQ-024 Reset asserted mid-SETTLE SHALL abort the wait; no pending closure is applied after release.

Configuration
REQ-025 Macro SW_DEADTIME_EN defined: the block SHALL implement REQ-015..REQ-020 as specified.
REQ-026 Macro SW_DEADTIME_EN undefined: sw_out<=tgt_q every cycle (2-cycle input-to-output latency), busy tied to 0, no FSM or counter.

Structure
REQ-027 Package sw_pkg SHALL hold the system_state, dac_top_state and pulse-phase encodings as localparams.
REQ-028 The target decode of REQ-013/014 SHALL be a combinational sub-module, sw_target_dec.

Verification (N_CH=16, DEAD_CYC=4)
REQ-029 key=1, SET from reset -> tgt_q=FFFF at cycle 1; sw_out=FFFF at cycle 6 (closure after dead time); busy high cycles 2..5.
REQ-030 TRAIN, mask1=00F0, V1_1, pulse1 1 then 3 -> sw_out 0000->00F0 after dead time, then 00F0->0000 two cycles after pulse1=3, with no wait.
REQ-031 sw_out=00F0 settled, target changes to 0F00 -> sw_out=0000 next cycle, then 0F00 exactly DEAD_CYC+1 cycles later.
REQ-032 Mid-SETTLE target change 0F00->F000 -> counter restarts, sw_out stays 0000, then F000 after full dead time.
REQ-033 key_state dropped during SETTLE -> sw_out=0000 and busy=0 next cycle; cfg_valid during TRAIN -> masks unchanged.
